// File: rtl/period_meter_pkg.sv
// period_meter shared types and defaults.
// State encoding for the arming/measure/lost controller.
package period_meter_pkg;

   typedef enum logic [1:0] {
      ARM_LOW,
      ARM_RISE,
      RUN,
      LOST
   } pm_state_t;

   localparam int unsigned PM_WIDTH_DEFAULT   = 32;
   localparam int unsigned PM_TIMEOUT_DEFAULT = 100_000_000;

endpackage

// File: rtl/period_meter_sync.sv
// sync_rise: two-flop synchronizer for an async input,
// plus one delay flop to detect a synchronized rising edge.
module sync_rise (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic s,
   output logic rise
);

   logic meta;
   logic s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         s    <= 1'b0;
         s_d  <= 1'b0;
      end else begin
         meta <= sig_in;
         s    <= meta;
         s_d  <= s;
      end
   end

   assign rise = s & ~s_d;

endmodule

// File: rtl/period_meter.sv
// period_meter: counts clk cycles per period and high time
// of a slow asynchronous square wave, with loss detection.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned WIDTH   = PM_WIDTH_DEFAULT,
   parameter int unsigned TIMEOUT = PM_TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             valid,
   output logic             timeout
);

   if (TIMEOUT < 2 ||
       (WIDTH < 64 && (64'(TIMEOUT) >= (64'd1 << WIDTH)))) begin : g_bad_cfg
      $error("period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);

   logic             s;
   logic             rise;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hcnt;
   pm_state_t        state;
   pm_state_t        state_nxt;
   logic             load;
   logic             timeout_nxt;

   sync_rise u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise)
   );

   // Counters only advance while measuring, so they saturate in LOST
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         hcnt <= '0;
      end else if (rise) begin
         cnt  <= ONE;
         hcnt <= ONE;
      end else if (state == RUN) begin
         cnt  <= cnt + ONE;
         hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s};
      end
   end

   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      timeout_nxt = timeout;
      unique case (state)
         ARM_LOW: begin
            if (!s) state_nxt = ARM_RISE;
         end
         ARM_RISE: begin
            if (rise) state_nxt = RUN;
         end
         RUN: begin
            if (rise) begin
               load = 1'b1;
            end else if (cnt == TO_CNT) begin
               state_nxt   = LOST;
               timeout_nxt = 1'b1;
            end
         end
         LOST: begin
            if (rise) begin
               state_nxt   = RUN;
               timeout_nxt = 1'b0;
            end
         end
         default: state_nxt = ARM_LOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARM_LOW;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid   <= load;
         timeout <= timeout_nxt;
         if (load) begin
            period    <= cnt;
            high_time <= hcnt;
         end
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: input-level reference model feeding a
// scoreboard of expected measurements for period_meter.
module tb_period_meter;

   localparam int W  = 16;
   localparam int TO = 100;
   localparam int LAT = 3;

   typedef struct {
      int due;
      int p;
      int h;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sig_in = 1'b1;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         timeout;

   period_meter #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   t      = 0;

   bit       m_prev  = 1'b0;
   bit       m_armed = 1'b0;
   bit       m_lost  = 1'b0;
   int       m_gap   = 0;
   int       m_high  = 0;
   bit [2:0] hist    = '0;
   int       exp_p   = 0;
   int       exp_h   = 0;

   task automatic check(input string tag, input int unsigned obs,
                        input int unsigned exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @tick %0d: got %0d, want %0d",
                  tag, t, obs, exp);
      end
   endtask

   // Compare DUT outputs against what the model predicted 3 ticks ago
   task automatic observe();
      if (sb.size() > 0 && sb[0].due == t) begin
         check("valid", valid, 1);
         check("period_upd", period, sb[0].p);
         check("high_upd", high_time, sb[0].h);
         exp_p = sb[0].p;
         exp_h = sb[0].h;
         void'(sb.pop_front());
      end else begin
         check("valid", valid, 0);
      end
      check("period", period, exp_p);
      check("high_time", high_time, exp_h);
      check("timeout", timeout, hist[2]);
   endtask

   task automatic model(input bit v);
      if (v && !m_prev) begin
         if (m_armed && !m_lost)
            sb.push_back('{due: t + LAT, p: m_gap, h: m_high});
         m_armed = 1'b1;
         m_lost  = 1'b0;
         m_gap   = 1;
         m_high  = 1;
      end else if (m_armed && !m_lost) begin
         if (m_gap == TO) begin
            m_lost = 1'b1;
         end else begin
            m_gap++;
            m_high += int'(v);
         end
      end
      m_prev = v;
      hist = {hist[1:0], m_lost};
   endtask

   task automatic tick(input bit v);
      @(negedge clk);
      observe();
      rst    = 1'b0;
      sig_in = v;
      model(v);
      t++;
   endtask

   task automatic do_reset(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         observe();
         rst    = 1'b1;
         sig_in = v;
         sb.delete();
         m_prev  = 1'b0;
         m_armed = 1'b0;
         m_lost  = 1'b0;
         m_gap   = 0;
         m_high  = 0;
         hist    = '0;
         exp_p   = 0;
         exp_h   = 0;
         t++;
      end
   endtask

   task automatic wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < p; i++)
            tick(i < h);
   endtask

   task automatic hold(input bit v, input int n);
      for (int i = 0; i < n; i++) tick(v);
   endtask

   initial begin
      // reset while high: no valid, no timeout, zero outputs
      do_reset(1'b1, 2);
      hold(1'b1, 20);
      do_reset(1'b0, 2);
      hold(1'b0, 5);

      // steady wave, then duty change with mixed transition
      wave(10, 4, 6);
      wave(12, 9, 4);

      // loss after a rise, then recovery
      wave(10, 4, 3);
      tick(1'b1);
      hold(1'b0, TO + 15);
      wave(10, 4, 3);

      // boundary: period exactly TIMEOUT
      wave(100, 50, 2);
      wave(10, 4, 2);

      // reset mid-period, then re-arm
      wave(10, 4, 3);
      hold(1'b1, 2);
      do_reset(1'b1, 1);
      hold(1'b0, 4);
      wave(10, 4, 4);
      hold(1'b0, 6);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
